control_dispatch: RTL and testbench

//  Parametrised successor of the 3-source opcode controller. Captures request edges from N_SRC

---
 rtl/control_pkg.sv | 25 ++
 rtl/control_dispatch_if.sv | 25 ++
 rtl/dispatch_arbiter.sv | 39 +++
 rtl/control_dispatch.sv | 119 +++++++++++
 tb/tb_control_dispatch.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared constants, state encoding and sizing helpers for control_dispatch
package control_pkg;

    localparam int OP_NOP = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/control_dispatch_if.sv
// rtl/control_dispatch_if.sv - request, opcode handshake and status bundle of control_dispatch
interface control_dispatch_if #(
    parameter int N_SRC = 3,
    parameter int OP_W  = 2
);
    logic [N_SRC-1:0] req_in;
    logic             op_ready_in;
    logic             op_done_in;
    logic [OP_W-1:0]  opcode_out;
    logic             op_valid_out;
    logic [N_SRC-1:0] grant_out;
    logic [N_SRC-1:0] pending_out;
    logic             busy_out;
    logic             timeout_out;

    modport master (
        input  req_in, op_ready_in, op_done_in,
        output opcode_out, op_valid_out, grant_out, pending_out, busy_out, timeout_out
    );

    modport slave (
        output req_in, op_ready_in, op_done_in,
        input  opcode_out, op_valid_out, grant_out, pending_out, busy_out, timeout_out
    );
endinterface

// File: rtl/dispatch_arbiter.sv
// rtl/dispatch_arbiter.sv - combinational fixed-priority / round-robin pick among pending sources
module dispatch_arbiter
    import control_pkg::*;
#(
    parameter int N_SRC   = 3,
    parameter int RR_MODE = 0,
    parameter int IDX_W   = clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] winner_onehot,
    output logic [IDX_W-1:0] winner_idx,
    output logic             winner_any
);

    logic [IDX_W-1:0] cand;

    // Candidates are scanned from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner_idx    = '0;
        winner_onehot = '0;
        cand          = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            if (RR_MODE != 0) begin
                cand = IDX_W'((int'(ptr) + k) % N_SRC);
            end else begin
                cand = IDX_W'(k - 1);
            end
            if (pending[cand]) begin
                winner_idx          = cand;
                winner_onehot       = '0;
                winner_onehot[cand] = 1'b1;
            end
        end
    end

    assign winner_any = |pending;

endmodule

// File: rtl/control_dispatch.sv
// rtl/control_dispatch.sv - edge-captured request dispatcher issuing one opcode at a time
module control_dispatch
    import control_pkg::*;
#(
    parameter int N_SRC       = 3,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT_CYC = 255,
    parameter int OP_W        = clog2(N_SRC + 1)
) (
    input logic                clk,
    input logic                reset_n,
    control_dispatch_if.master bus
);

    localparam int IDX_W = clog2(N_SRC);
    localparam int TMR_W = max1(clog2(TIMEOUT_CYC + 1));
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t           state;
    logic [N_SRC-1:0] req_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] grant;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [OP_W-1:0]  opcode;
    logic             valid;
    logic             busy;
    logic             timeout;
    logic [TMR_W-1:0] timer;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] arb_onehot;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    assign rise = bus.req_in & ~req_q;
    // A rise in the accept cycle re-sets the bit, so the source gets served again.
    assign clr  = (state == ST_ISSUE && bus.op_ready_in) ? grant : '0;

    dispatch_arbiter #(
        .N_SRC   (N_SRC),
        .RR_MODE (RR_MODE),
        .IDX_W   (IDX_W)
    ) u_arb (
        .pending       (pending),
        .ptr           (ptr),
        .winner_onehot (arb_onehot),
        .winner_idx    (arb_idx),
        .winner_any    (arb_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            pending <= '0;
            grant   <= '0;
            ptr     <= IDX_W'(N_SRC - 1);
            win_idx <= '0;
            opcode  <= OP_W'(OP_NOP);
            valid   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            timer   <= '0;
        end else begin
            req_q   <= bus.req_in;
            pending <= (pending & ~clr) | rise;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        opcode  <= OP_W'(arb_idx) + OP_W'(1);
                        grant   <= arb_onehot;
                        win_idx <= arb_idx;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.op_ready_in) begin
                        valid <= 1'b0;
                        timer <= '0;
                        ptr   <= win_idx;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.op_done_in) begin
                        opcode <= OP_W'(OP_NOP);
                        grant  <= '0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (TIMEOUT_CYC != 0 && timer == TMR_LAST) begin
                        timeout <= 1'b1;
                        opcode  <= OP_W'(OP_NOP);
                        grant   <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (TIMEOUT_CYC != 0) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.opcode_out   = opcode;
    assign bus.op_valid_out = valid;
    assign bus.grant_out    = grant;
    assign bus.pending_out  = pending;
    assign bus.busy_out     = busy;
    assign bus.timeout_out  = timeout;

endmodule

// File: tb/tb_control_dispatch.sv
// tb/tb_control_dispatch.sv - directed bench for control_dispatch (fixed-priority and round-robin)
module tb_control_dispatch;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    control_dispatch_if #(.N_SRC(3), .OP_W(2)) bf ();
    control_dispatch_if #(.N_SRC(3), .OP_W(2)) br ();

    control_dispatch #(
        .N_SRC       (3),
        .RR_MODE     (0),
        .TIMEOUT_CYC (4)
    ) u_fp (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bf)
    );

    control_dispatch #(
        .N_SRC       (3),
        .RR_MODE     (1),
        .TIMEOUT_CYC (0)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (br)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int rr_exp [6] = '{1, 2, 3, 1, 2, 3};

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bf.req_in = '0; bf.op_ready_in = 1'b0; bf.op_done_in = 1'b0;
        br.req_in = '0; br.op_ready_in = 1'b0; br.op_done_in = 1'b0;
        repeat (2) tick();
        check("rst_opcode",  32'(bf.opcode_out),   0);
        check("rst_valid",   32'(bf.op_valid_out), 0);
        check("rst_grant",   32'(bf.grant_out),    0);
        check("rst_pending", 32'(bf.pending_out),  0);
        check("rst_busy",    32'(bf.busy_out),     0);
        check("rst_timeout", 32'(bf.timeout_out),  0);
        reset_n = 1'b1;
        tick();

        // single request on source 1
        bf.req_in = 3'b010;
        tick();
        check("single_pending", 32'(bf.pending_out),  2);
        check("single_novalid", 32'(bf.op_valid_out), 0);
        tick();
        check("single_valid",  32'(bf.op_valid_out), 1);
        check("single_opcode", 32'(bf.opcode_out),   2);
        check("single_grant",  32'(bf.grant_out),    2);
        check("single_busy",   32'(bf.busy_out),     1);
        bf.op_ready_in = 1'b1;
        tick();
        bf.op_ready_in = 1'b0;
        check("single_acc_valid",   32'(bf.op_valid_out), 0);
        check("single_acc_opcode",  32'(bf.opcode_out),   2);
        check("single_acc_pending", 32'(bf.pending_out),  0);
        bf.op_done_in = 1'b1;
        tick();
        bf.op_done_in = 1'b0;
        check("single_done_opcode", 32'(bf.opcode_out), 0);
        check("single_done_grant",  32'(bf.grant_out),  0);
        check("single_done_busy",   32'(bf.busy_out),   0);
        repeat (3) tick();
        check("single_held_valid",   32'(bf.op_valid_out), 0);
        check("single_held_pending", 32'(bf.pending_out),  0);
        bf.req_in = '0;
        tick();

        // fixed priority: src0 and src2 together
        bf.req_in = 3'b101;
        tick();
        check("fp_pending", 32'(bf.pending_out), 5);
        tick();
        check("fp_first_opcode", 32'(bf.opcode_out), 1);
        check("fp_first_grant",  32'(bf.grant_out),  1);
        bf.op_ready_in = 1'b1;
        tick();
        bf.op_ready_in = 1'b0;
        check("fp_pending_during", 32'(bf.pending_out), 4);
        bf.op_done_in = 1'b1;
        tick();
        bf.op_done_in = 1'b0;
        check("fp_gap_valid",  32'(bf.op_valid_out), 0);
        check("fp_gap_opcode", 32'(bf.opcode_out),   0);
        tick();
        check("fp_second_valid",  32'(bf.op_valid_out), 1);
        check("fp_second_opcode", 32'(bf.opcode_out),   3);
        check("fp_second_grant",  32'(bf.grant_out),    4);
        bf.op_ready_in = 1'b1;
        tick();
        bf.op_ready_in = 1'b0;
        bf.op_done_in = 1'b1;
        tick();
        bf.op_done_in = 1'b0;
        bf.req_in = '0;
        tick();
        check("fp_end_pending", 32'(bf.pending_out), 0);

        // timeout after 4 BUSY cycles
        bf.req_in = 3'b001;
        tick();
        bf.req_in = '0;
        tick();
        check("to_opcode", 32'(bf.opcode_out), 1);
        bf.op_ready_in = 1'b1;
        tick();
        bf.op_ready_in = 1'b0;
        check("to_busy_enter", 32'(bf.busy_out), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait_timeout", 32'(bf.timeout_out), 0);
            check("to_wait_busy",    32'(bf.busy_out),    1);
        end
        tick();
        check("to_pulse",        32'(bf.timeout_out), 1);
        check("to_pulse_busy",   32'(bf.busy_out),    0);
        check("to_pulse_opcode", 32'(bf.opcode_out),  0);
        tick();
        check("to_pulse_once", 32'(bf.timeout_out), 0);

        // done in the abort cycle wins
        bf.req_in = 3'b001;
        tick();
        bf.req_in = '0;
        tick();
        bf.op_ready_in = 1'b1;
        tick();
        bf.op_ready_in = 1'b0;
        repeat (3) tick();
        bf.op_done_in = 1'b1;
        tick();
        bf.op_done_in = 1'b0;
        check("to_done_nopulse", 32'(bf.timeout_out), 0);
        check("to_done_busy",    32'(bf.busy_out),    0);
        tick();
        check("to_done_after", 32'(bf.timeout_out), 0);

        // stall in ISSUE, then re-rise in accept cycle
        bf.req_in = 3'b100;
        tick();
        tick();
        bf.req_in = '0;
        check("stall_opcode0", 32'(bf.opcode_out), 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid",  32'(bf.op_valid_out), 1);
            check("stall_opcode", 32'(bf.opcode_out),   3);
        end
        bf.op_ready_in = 1'b1;
        bf.req_in = 3'b100;
        tick();
        bf.op_ready_in = 1'b0;
        check("rerise_pending", 32'(bf.pending_out), 4);
        check("rerise_busy",    32'(bf.busy_out),    1);
        bf.op_done_in = 1'b1;
        tick();
        bf.op_done_in = 1'b0;
        check("rerise_idle_opcode", 32'(bf.opcode_out), 0);
        tick();
        check("rerise_again_valid",  32'(bf.op_valid_out), 1);
        check("rerise_again_opcode", 32'(bf.opcode_out),   3);
        check("rerise_again_grant",  32'(bf.grant_out),    4);
        bf.op_ready_in = 1'b1;
        tick();
        bf.op_ready_in = 1'b0;
        bf.op_done_in = 1'b1;
        tick();
        bf.op_done_in = 1'b0;
        bf.req_in = '0;
        check("rerise_end_pending", 32'(bf.pending_out), 0);
        check("rerise_end_busy",    32'(bf.busy_out),    0);

        // round-robin: all sources re-pulse after each op
        for (int i = 0; i < 6; i++) begin
            br.req_in = 3'b111;
            tick();
            tick();
            check("rr_valid",  32'(br.op_valid_out), 1);
            check("rr_opcode", 32'(br.opcode_out),   32'(rr_exp[i]));
            check("rr_grant",  32'(br.grant_out),    32'(1 << (rr_exp[i] - 1)));
            br.op_ready_in = 1'b1;
            tick();
            br.op_ready_in = 1'b0;
            br.req_in = '0;
            br.op_done_in = 1'b1;
            tick();
            br.op_done_in = 1'b0;
        end

        // asynchronous reset while BUSY with another request pending
        bf.req_in = 3'b010;
        tick();
        tick();
        bf.op_ready_in = 1'b1;
        tick();
        bf.op_ready_in = 1'b0;
        bf.req_in = 3'b011;
        tick();
        check("mid_busy",    32'(bf.busy_out),    1);
        check("mid_pending", 32'(bf.pending_out), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_opcode",  32'(bf.opcode_out),   0);
        check("async_valid",   32'(bf.op_valid_out), 0);
        check("async_grant",   32'(bf.grant_out),    0);
        check("async_pending", 32'(bf.pending_out),  0);
        check("async_busy",    32'(bf.busy_out),     0);
        bf.req_in = '0;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy",    32'(bf.busy_out),    0);
        check("post_rst_timeout", 32'(bf.timeout_out), 0);
        check("post_rst_pending", 32'(bf.pending_out), 0);
        check("post_rst_valid",   32'(bf.op_valid_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
